// File: rtl/bit_write_ctrl.sv
// Button/switch input stage: synchronizes raw inputs, debounces the button and
// emits one write strobe with a captured bit_index/bit_value per accepted press.
module bit_write_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       btn_in,
    input  logic [2:0] sw_index,
    input  logic       sw_value,
    output logic       valid_out,
    output logic [2:0] bit_index,
    output logic       bit_value,
    output logic       busy
);

    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned SYNC_W = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // Synchronizer vector layout: {btn, index[2:0], value}
    logic [SYNC_W-1:0] sync1_q, sync1_d;
    logic [SYNC_W-1:0] sync2_q, sync2_d;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic [2:0]        index_q, index_d;
    logic              value_q, value_d;

    logic              btn_s;
    logic [2:0]        sw_index_s;
    logic              sw_value_s;

    assign btn_s      = sync2_q[4];
    assign sw_index_s = sync2_q[3:1];
    assign sw_value_s = sync2_q[0];

    assign sync1_d = {btn_in, sw_index, sw_value};
    assign sync2_d = sync1_q;

    always_ff @(posedge CLK) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            index_q <= 3'd0;
            value_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            index_q <= index_d;
            value_q <= value_d;
        end
    end

    // Debounce FSM; the strobe and switch capture share the accepting edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        index_d = index_q;
        value_d = value_q;
        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    valid_d = 1'b1;
                    index_d = sw_index_s;
                    value_d = sw_value_s;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign valid_out = valid_q;
    assign bit_index = index_q;
    assign bit_value = value_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bit_write_ctrl.sv
// Scoreboard bench for bit_write_ctrl: a run-length model of the debounced
// button predicts strobes; a monitor checks every cycle after the clock edge.
module tb_bit_write_ctrl;

    localparam int unsigned D = 4;

    logic       CLK = 1'b0;
    logic       rst;
    logic       btn_in;
    logic [2:0] sw_index;
    logic       sw_value;
    logic       valid_out;
    logic [2:0] bit_index;
    logic       bit_value;
    logic       busy;

    bit_write_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .CLK       (CLK),
        .rst       (rst),
        .btn_in    (btn_in),
        .sw_index  (sw_index),
        .sw_value  (sw_value),
        .valid_out (valid_out),
        .bit_index (bit_index),
        .bit_value (bit_value),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         edge_no;
        logic [2:0] idx;
        logic       val;
    } strobe_t;

    strobe_t exp_q[$];

    int n_chk  = 0;
    int n_pass = 0;
    int dut_strobes = 0;

    // Model state: two-stage input delay plus run lengths of the settled button.
    int         edge_no = 0;
    logic       m_btn1, m_btn2, m_val1, m_val2;
    logic [2:0] m_idx1, m_idx2;
    bit         armed;
    int         ones, zeros;
    logic [2:0] exp_idx;
    logic       exp_val;
    logic       exp_busy;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_no);
    endtask

    // Advance the model across the upcoming clock edge using the driven inputs.
    task automatic tick();
        strobe_t s;
        edge_no++;
        if (rst) begin
            {m_btn1, m_btn2, m_val1, m_val2} = '0;
            m_idx1 = '0; m_idx2 = '0;
            armed = 1; ones = 0; zeros = 0;
            exp_idx = '0; exp_val = 1'b0;
        end else begin
            if (armed) begin
                ones = m_btn2 ? ones + 1 : 0;
                if (ones == D + 1) begin
                    s.edge_no = edge_no; s.idx = m_idx2; s.val = m_val2;
                    exp_q.push_back(s);
                    exp_idx = m_idx2; exp_val = m_val2;
                    armed = 0; ones = 0; zeros = 0;
                end
            end else begin
                zeros = !m_btn2 ? zeros + 1 : 0;
                if (zeros == D + 1) begin
                    armed = 1; ones = 0;
                end
            end
            m_btn2 = m_btn1; m_idx2 = m_idx1; m_val2 = m_val1;
            m_btn1 = btn_in; m_idx1 = sw_index; m_val1 = sw_value;
        end
        exp_busy = !(armed && ones == 0);
    endtask

    task automatic cyc(input logic b, input logic [2:0] i, input logic v, input logic r);
        @(negedge CLK);
        btn_in = b; sw_index = i; sw_value = v; rst = r;
        tick();
    endtask

    task automatic hold(input int n, input logic b, input logic [2:0] i, input logic v);
        for (int k = 0; k < n; k++) cyc(b, i, v, 1'b0);
    endtask

    // Monitor: pops the scoreboard on every strobe and checks held outputs.
    initial begin
        strobe_t s;
        forever begin
            @(posedge CLK);
            #1;
            if (valid_out === 1'b1) begin
                dut_strobes++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    s = exp_q.pop_front();
                    chk("strobe_edge", edge_no, s.edge_no);
                    chk("strobe_index", int'(bit_index), int'(s.idx));
                    chk("strobe_value", int'(bit_value), int'(s.val));
                end
            end else begin
                chk("valid_low", int'(valid_out), 0);
                if (exp_q.size() != 0 && exp_q[0].edge_no <= edge_no) begin
                    s = exp_q.pop_front();
                    chk("missed_strobe", 0, 1);
                end
            end
            chk("busy", int'(busy), int'(exp_busy));
            chk("bit_index_hold", int'(bit_index), int'(exp_idx));
            chk("bit_value_hold", int'(bit_value), int'(exp_val));
        end
    end

    initial begin
        int base;
        int len;
        logic b;
        btn_in = 1'b1; sw_index = 3'd0; sw_value = 1'b0; rst = 1'b1;
        tick();

        // 1: reset with button held, then one strobe after release of rst
        cyc(1'b1, 3'd0, 1'b0, 1'b1);
        cyc(1'b1, 3'd0, 1'b0, 1'b1);
        base = dut_strobes;
        hold(10, 1'b1, 3'd0, 1'b0);
        hold(8, 1'b0, 3'd0, 1'b0);
        chk("plan1_strobes", dut_strobes - base, 1);

        // 2: clean press
        base = dut_strobes;
        hold(20, 1'b1, 3'd5, 1'b1);
        hold(8, 1'b0, 3'd5, 1'b1);
        chk("plan2_strobes", dut_strobes - base, 1);

        // 3: press bounce rejected
        base = dut_strobes;
        hold(2, 1'b1, 3'd3, 1'b1);
        hold(1, 1'b0, 3'd3, 1'b1);
        hold(2, 1'b1, 3'd3, 1'b1);
        hold(8, 1'b0, 3'd3, 1'b1);
        chk("plan3_strobes", dut_strobes - base, 0);

        // 4: release bounce, then full release and new press
        base = dut_strobes;
        hold(10, 1'b1, 3'd5, 1'b1);
        for (int k = 0; k < 5; k++) begin
            hold(1, 1'b0, 3'd5, 1'b1);
            hold(1, 1'b1, 3'd5, 1'b1);
        end
        hold(6, 1'b1, 3'd5, 1'b1);
        chk("plan4_release_bounce", dut_strobes - base, 1);
        hold(8, 1'b0, 3'd2, 1'b0);
        hold(10, 1'b1, 3'd2, 1'b0);
        hold(8, 1'b0, 3'd2, 1'b0);
        chk("plan4_strobes", dut_strobes - base, 2);
        chk("plan4_index", int'(bit_index), 2);

        // 5: switch change while held
        base = dut_strobes;
        hold(10, 1'b1, 3'd5, 1'b1);
        hold(10, 1'b1, 3'd7, 1'b0);
        chk("plan5_index", int'(bit_index), 5);
        hold(8, 1'b0, 3'd7, 1'b0);
        chk("plan5_strobes", dut_strobes - base, 1);

        // 6: reset mid-debounce, button still high
        base = dut_strobes;
        hold(4, 1'b1, 3'd1, 1'b1);
        cyc(1'b1, 3'd1, 1'b1, 1'b1);
        hold(10, 1'b1, 3'd1, 1'b1);
        hold(8, 1'b0, 3'd1, 1'b1);
        chk("plan6_strobes", dut_strobes - base, 1);

        // Random bouncing button, wandering switches, occasional reset
        for (int k = 0; k < 400; k++) begin
            b = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 8));
            for (int j = 0; j < len; j++)
                cyc(b, 3'($urandom), 1'($urandom), 1'($urandom_range(0, 199) == 0));
        end
        hold(12, 1'b0, 3'd0, 1'b0);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bit_write_ctrl.md
Name: bit_write_ctrl

Overview:
Upstream input stage for the bit-write / seven-segment display block. It synchronizes a push button and four slide switches, then debounces the button. For each debounced press it emits exactly one single-cycle write strobe (valid_out), carrying a stable bit_index / bit_value pair. Outputs connect directly to the display block's valid_in, bit_index and bit_value.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a press or a release. Default is 10 ms at 100 MHz. Minimum 2. Benches use 4.
- CNT_W, $clog2(DEBOUNCE_CYCLES): debounce counter width. Derived; not overridden.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- btn_in  input  1  raw push button, asynchronous, bouncy.
- sw_index  input  3  raw switches selecting the bit position, asynchronous.
- sw_value  input  1  raw switch giving the bit value, asynchronous.
- valid_out  output  1  one-cycle write strobe per debounced press.
- bit_index  output  3  captured index; stable between strobes.
- bit_value  output  1  captured value; stable between strobes.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Synchronizers:
  - btn_in, sw_index and sw_value each pass through a 2-flop synchronizer (sync1 -> sync2). FSM and capture use only the sync2 values.
  - All synchronizer flops reset to 0.
- Reset, sampled on posedge CLK with rst=1:
  - state=IDLE, cnt=0.
  - valid_out=0, bit_index=3'd0, bit_value=0, busy=0.
  - rst takes priority over all other activity, including mid-debounce; no strobe is produced on a reset cycle.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - IDLE: btn_s=1 -> PRESS_WAIT with cnt<=0. Otherwise stay.
  - PRESS_WAIT:
    - btn_s=0 -> IDLE (bounce rejected; no strobe).
    - btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD; on that same edge valid_out<=1, bit_index<=sw_index_s, bit_value<=sw_value_s.
    - Otherwise cnt<=cnt+1.
  - HELD: btn_s=0 -> RELEASE_WAIT with cnt<=0. Holding the button produces no further strobes (no auto-repeat).
  - RELEASE_WAIT:
    - btn_s=1 -> HELD (release bounce; no strobe).
    - btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE.
    - Otherwise cnt<=cnt+1.
- valid_out is registered and high for exactly one cycle. On every edge it is cleared unless the capture condition holds.
- Latency: if btn_in rises before edge k and stays high, valid_out is high in the cycle after edge k+2+DEBOUNCE_CYCLES. With DEBOUNCE_CYCLES=4 this is after edge k+6.
- Capture uses switch values synchronized at the capture edge only. Switch changes at any other time never alter the outputs.
- busy = (state != IDLE), registered-state derived.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around is possible.
- Button held high through reset: after rst deasserts, the synchronizers refill and the press is debounced as a new press. One strobe results.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset: hold rst=1 for 3 cycles with btn_in=1 -> during reset valid_out=0, bit_index=0, bit_value=0, busy=0. After release, one strobe 6 edges later.
2. Clean press: sw_index=3'd5, sw_value=1, btn_in rises before edge k and is held 20 cycles -> valid_out=1 only after edge k+6; bit_index=5, bit_value=1; busy=1 from edge k+2.
3. Bounce rejection: btn_in pulses high 2 cycles, low 1, high 2, then low -> no valid_out; FSM returns to IDLE; busy drops.
4. Release bounce: after a strobe, btn_in toggles low/high every 2 cycles for 10 cycles, then stays high -> no second strobe. A full release of 6+ cycles followed by a new press with sw_index=2, sw_value=0 -> one strobe, bit_index=2, bit_value=0.
5. Switch change while held: after a strobe with index 5, change sw_index to 7 while btn_in stays high -> bit_index remains 5 and valid_out remains 0.
6. Reset mid-debounce: assert rst for 1 cycle at edge k+4 of a press -> no strobe from that press. With btn still high, a strobe occurs 6 edges after rst deasserts.
